// File: rtl/robot_pkg.sv
// Shared encodings for the wall-following robot controller:
// FSM state values and rotation direction constants.
package robot_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        FOLLOW = 2'd1,
        ROTATE = 2'd2,
        STUCK  = 2'd3
    } state_t;

    localparam logic DIR_CCW = 1'b0;
    localparam logic DIR_CW  = 1'b1;

endpackage

// File: rtl/sensor_debounce.sv
// Single-sensor debounce filter: the filtered value follows the raw
// input only after DEB consecutive mismatching samples.
module sensor_debounce #(
    parameter int DEB = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(DEB + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw == filt) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            filt <= raw;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wall_follow_ctrl.sv
// Wall-following controller: debounced sensors feed a Moore FSM that
// searches, follows a wall, turns in timed steps and flags a stuck robot.
module wall_follow_ctrl
    import robot_pkg::*;
#(
    parameter int DEB         = 2,
    parameter int ROT_CYCLES  = 4,
    parameter int LOST_LIMIT  = 8,
    parameter int STUCK_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       side,
    input  logic       head,
    input  logic       wall,
    output logic       front,
    output logic       rotate,
    output logic       rot_dir,
    output logic       stuck,
    output logic [1:0] state
);

    localparam int LW = $clog2(LOST_LIMIT + 1);
    localparam int RW = $clog2(ROT_CYCLES + 1);
    localparam int SW = $clog2(STUCK_LIMIT + 1);

    localparam logic [LW-1:0] LOST_LAST = LW'(LOST_LIMIT - 1);
    localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_LIMIT);

    state_t        st;
    logic          head_f;
    logic          wall_f;
    logic [LW-1:0] lost_cnt;
    logic [RW-1:0] rot_cnt;
    logic [SW-1:0] stuck_cnt;
    logic [SW-1:0] stuck_nxt;
    logic          dir_away;
    logic          dir_toward;

    sensor_debounce #(.DEB(DEB)) u_head_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (head),
        .filt  (head_f)
    );

    sensor_debounce #(.DEB(DEB)) u_wall_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (wall),
        .filt  (wall_f)
    );

    assign dir_away   = side ? DIR_CCW : DIR_CW;
    assign dir_toward = side ? DIR_CW : DIR_CCW;

    // Saturating so a long stuck episode can never wrap back to zero.
    assign stuck_nxt = (stuck_cnt == STUCK_MAX) ? stuck_cnt
                                                : stuck_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= SEARCH;
            rot_dir   <= DIR_CCW;
            lost_cnt  <= '0;
            rot_cnt   <= '0;
            stuck_cnt <= '0;
        end else if (!en) begin
            st        <= SEARCH;
            lost_cnt  <= '0;
            rot_cnt   <= '0;
            stuck_cnt <= '0;
        end else begin
            unique case (st)
                SEARCH: begin
                    stuck_cnt <= '0;
                    if (head_f) begin
                        st      <= ROTATE;
                        rot_dir <= dir_away;
                        rot_cnt <= '0;
                    end else if (wall_f) begin
                        st <= FOLLOW;
                    end
                end
                FOLLOW: begin
                    stuck_cnt <= '0;
                    if (head_f) begin
                        st       <= ROTATE;
                        rot_dir  <= dir_away;
                        rot_cnt  <= '0;
                        lost_cnt <= '0;
                    end else if (wall_f) begin
                        lost_cnt <= '0;
                    end else if (lost_cnt == LOST_LAST) begin
                        st       <= ROTATE;
                        rot_dir  <= dir_toward;
                        rot_cnt  <= '0;
                        lost_cnt <= '0;
                    end else begin
                        lost_cnt <= lost_cnt + 1'b1;
                    end
                end
                ROTATE: begin
                    if (rot_cnt == ROT_LAST) begin
                        rot_cnt   <= '0;
                        stuck_cnt <= stuck_nxt;
                        if (stuck_nxt == STUCK_MAX) begin
                            st <= STUCK;
                        end else if (head_f) begin
                            st <= ROTATE;
                        end else if (wall_f) begin
                            st <= FOLLOW;
                        end else begin
                            st <= SEARCH;
                        end
                    end else begin
                        rot_cnt <= rot_cnt + 1'b1;
                    end
                end
                STUCK: begin
                    st <= STUCK;
                end
            endcase
        end
    end

    assign front  = en & ((st == SEARCH) | (st == FOLLOW));
    assign rotate = (st == ROTATE);
    assign stuck  = (st == STUCK);
    assign state  = st;

endmodule

// File: tb/tb_wall_follow_ctrl.sv
// Directed scenarios plus a randomized phase, every cycle compared
// against an integer-level behavioural model of the controller.
module tb_wall_follow_ctrl;

    localparam int DEB  = 2;
    localparam int ROT  = 4;
    localparam int LOST = 8;
    localparam int STK  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic side = 1'b0;
    logic head = 1'b0;
    logic wall = 1'b0;
    logic front, rotate, rot_dir, stuck;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // model: filtered sensors, mismatch run lengths, mode and timers
    int m_hf, m_wf, m_hrun, m_wrun;
    int m_st, m_dir, m_lost, m_left, m_steps;

    always #5 clk = ~clk;

    wall_follow_ctrl #(
        .DEB(DEB), .ROT_CYCLES(ROT),
        .LOST_LIMIT(LOST), .STUCK_LIMIT(STK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .side(side),
        .head(head), .wall(wall), .front(front),
        .rotate(rotate), .rot_dir(rot_dir), .stuck(stuck),
        .state(state)
    );

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_hf = 0; m_wf = 0; m_hrun = 0; m_wrun = 0;
        m_st = 0; m_dir = 0; m_lost = 0; m_left = 0; m_steps = 0;
    endfunction

    function automatic void m_filter(input int raw, inout int f,
                                     inout int run);
        if (raw != f) begin
            run++;
            if (run >= DEB) begin
                f = raw;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    function automatic void m_start_turn(input int dir);
        m_st = 2;
        m_dir = dir;
        m_left = ROT;
    endfunction

    function automatic void m_step();
        int away, toward;
        away = side ? 0 : 1;
        toward = side ? 1 : 0;
        if (!en) begin
            m_st = 0; m_lost = 0; m_left = 0; m_steps = 0;
        end else if (m_st == 0) begin
            m_steps = 0;
            if (m_hf == 1) m_start_turn(away);
            else if (m_wf == 1) m_st = 1;
        end else if (m_st == 1) begin
            m_steps = 0;
            if (m_hf == 1) begin
                m_start_turn(away);
                m_lost = 0;
            end else if (m_wf == 1) begin
                m_lost = 0;
            end else begin
                m_lost++;
                if (m_lost == LOST) begin
                    m_start_turn(toward);
                    m_lost = 0;
                end
            end
        end else if (m_st == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_steps++;
                if (m_steps == STK) m_st = 3;
                else if (m_hf == 1) m_left = ROT;
                else if (m_wf == 1) m_st = 1;
                else m_st = 0;
            end
        end
        m_filter(int'(head), m_hf, m_hrun);
        m_filter(int'(wall), m_wf, m_wrun);
    endfunction

    task automatic cmp_all();
        chk("state", state, 2'(m_st));
        chk("front", {1'b0, front}, {1'b0, en && m_st < 2});
        chk("rotate", {1'b0, rotate}, {1'b0, m_st == 2});
        chk("stuck", {1'b0, stuck}, {1'b0, m_st == 3});
        chk("rot_dir", {1'b0, rot_dir}, 2'(m_dir));
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        cmp_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        en = 1'b1;
        m_reset();
        #2;
        chk("rst_state", state, 2'd0);
        chk("rst_front", {1'b0, front}, 2'd1);
        chk("rst_rotate", {1'b0, rotate}, 2'd0);
        chk("rst_stuck", {1'b0, stuck}, 2'd0);
        chk("rst_dir", {1'b0, rot_dir}, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: asynchronous reset in the middle of a rotation
        head = 1'b1;
        ticks(4);
        chk("s1_in_rot", {1'b0, rotate}, 2'd1);
        #3;
        rst_n = 1'b0;
        head = 1'b0;
        m_reset();
        #1;
        chk("s1_async_rot", {1'b0, rotate}, 2'd0);
        chk("s1_async_st", state, 2'd0);
        #2;
        rst_n = 1'b1;
        chk("s1_front", {1'b0, front}, 2'd1);

        // 2: single-cycle glitch rejected, held obstacle turns away
        head = 1'b1;
        tick();
        head = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s2_glitch_rot", {1'b0, rotate}, 2'd0);
            chk("s2_glitch_front", {1'b0, front}, 2'd1);
        end
        head = 1'b1;
        ticks(2);
        chk("s2_edge2", {1'b0, rotate}, 2'd0);
        tick();
        chk("s2_edge3_rot", {1'b0, rotate}, 2'd1);
        chk("s2_edge3_dir", {1'b0, rot_dir}, 2'd1);
        head = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_hold", {1'b0, rotate}, 2'd1);
        end
        tick();
        chk("s2_done", {1'b0, rotate}, 2'd0);
        chk("s2_search", state, 2'd0);

        // 3: follow, lose the wall, corner turn toward it
        wall = 1'b1;
        ticks(3);
        chk("s3_follow", state, 2'd1);
        wall = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("s3_still_follow", state, 2'd1);
        end
        tick();
        chk("s3_corner", state, 2'd2);
        chk("s3_corner_dir", {1'b0, rot_dir}, 2'd0);
        ticks(3);
        chk("s3_rot_end", state, 2'd2);
        tick();
        chk("s3_search", state, 2'd0);

        // 4: continuous obstacle ends in STUCK
        head = 1'b1;
        ticks(2);
        for (int i = 0; i < 4 * ROT; i++) begin
            tick();
            chk("s4_rot", {1'b0, rotate}, 2'd1);
        end
        tick();
        chk("s4_state", state, 2'd3);
        chk("s4_stuck", {1'b0, stuck}, 2'd1);
        chk("s4_front", {1'b0, front}, 2'd0);
        chk("s4_rotate", {1'b0, rotate}, 2'd0);
        en = 1'b0;
        tick();
        chk("s4_clr_state", state, 2'd0);
        chk("s4_clr_stuck", {1'b0, stuck}, 2'd0);
        en = 1'b1;
        head = 1'b0;
        ticks(10);

        // 6: enable gating
        en = 1'b0;
        head = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_front", {1'b0, front}, 2'd0);
            chk("s6_state", state, 2'd0);
        end
        en = 1'b1;
        #1;
        chk("s6_front_on", {1'b0, front}, 2'd1);
        tick();
        chk("s6_rotate", state, 2'd2);
        head = 1'b0;
        ticks(6);

        // 5: right-hand mode, latched direction
        side = 1'b1;
        wall = 1'b1;
        ticks(3);
        chk("s5_follow", state, 2'd1);
        head = 1'b1;
        ticks(3);
        chk("s5_rot", state, 2'd2);
        chk("s5_dir", {1'b0, rot_dir}, 2'd0);
        side = 1'b0;
        tick();
        chk("s5_dir_held", {1'b0, rot_dir}, 2'd0);
        head = 1'b0;
        wall = 1'b0;
        ticks(8);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 39) == 0) side = ~side;
            if ($urandom_range(0, 5) == 0) head = ~head;
            if ($urandom_range(0, 4) == 0) wall = ~wall;
            if ($urandom_range(0, 399) == 0) begin
                #3;
                rst_n = 1'b0;
                m_reset();
                #1;
                cmp_all();
                #1;
                rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
